db_cbf_ram_ctrl: RTL and testbench
==================================

# db_cbf_ram_ctrl

Access controller for the 64x16 deblocking CBF single-port RAM (`db_cbf_ram_sp_64x16`). It arbitrates one write requester (CBF producer from the TQ/recon stage) and one read requester (deblocking filter) onto the single RAM port. It also runs an optional whole-RAM clear sequence before each CTU. It sits between those two stages and the RAM instance, and drives its low-active `cen`/`wen` directly.

## Interface
Parameters:
- `ADR_W`, default 6, RAM address width (depth = 2^ADR_W = 64).
- `DAT_W`, default 16, RAM word width.
- `CLR_VAL`, default 16'h0000, word written to every address during clear.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_req_i`  in  1  write request, held until `wr_ack_o`.
- `wr_adr_i`  in  ADR_W  write address, stable while `wr_req_i` is high.
- `wr_dat_i`  in  DAT_W  write data, stable while `wr_req_i` is high.
- `wr_ack_o`  out  1  1-cycle pulse in the cycle the write is issued to the RAM.
- `rd_req_i`  in  1  read request, held until `rd_ack_o`.
- `rd_adr_i`  in  ADR_W  read address, stable while `rd_req_i` is high.
- `rd_ack_o`  out  1  1-cycle pulse in the cycle the read is issued.
- `rd_val_o`  out  1  read data valid, 1 cycle after `rd_ack_o`.
- `rd_dat_o`  out  DAT_W  read data, meaningful only while `rd_val_o` is high.
- `clr_start_i`  in  1  pulse that starts the clear sequence.
- `clr_busy_o`  out  1  high while clear is running.
- `clr_done_o`  out  1  1-cycle pulse when clear completes.
- `ram_cen_o`  out  1  RAM chip enable, low active.
- `ram_wen_o`  out  1  RAM write enable, low active.
- `ram_adr_o`  out  ADR_W  RAM address.
- `ram_wr_dat_o`  out  DAT_W  RAM write data.
- `ram_rd_dat_i`  in  DAT_W  RAM read data, valid 1 cycle after a read.

## Operation
- FSM states are IDLE and CLEAR; the state is registered.
- IDLE:
  - Serves `wr_req_i` and `rd_req_i`. At most one access per cycle.
  - Grant logic is combinational from the current state, the requests and the round-robin pointer.
- Arbitration:
  - Only one requester pending: that requester is granted.
  - Both pending, addresses differ: round-robin; the pointer toggles after each contended grant. Initial pointer after reset favours write.
  - Both pending, same address: write always wins; the read is granted in the following cycle and returns the new data. The pointer is not updated in this case.
- On a write grant: `ram_cen_o`=0, `ram_wen_o`=0, address and data from the write port, `wr_ack_o`=1.
- On a read grant: `ram_cen_o`=0, `ram_wen_o`=1, address from the read port, `rd_ack_o`=1.
- `rd_val_o` is a register set to the read-grant value. `rd_dat_o` = `ram_rd_dat_i` passed through.
- No grant in a cycle: `ram_cen_o`=1, `ram_wen_o`=1, and `ram_adr_o`/`ram_wr_dat_o` hold their last values.
- `clr_start_i` in IDLE:
  - Moves the FSM to CLEAR and resets a 6-bit counter to 0.
  - An access granted in that same cycle still completes; clear has priority from the next cycle.
- CLEAR:
  - Writes `CLR_VAL` to address = counter every cycle.
  - No acks are issued; requests stay pending.
  - The counter wraps 63→0, and the FSM returns to IDLE after the address-63 write.
- `clr_start_i` while in CLEAR is ignored.

## Timing
- Write: ack and RAM write happen in the same cycle T as the grant.
- Read: ack and RAM read in cycle T; `rd_val_o`/`rd_dat_o` in cycle T+1.
- Back-to-back reads give 1 result per cycle.
- Clear:
  - `clr_busy_o` is high from cycle S+1 to S+64, where S is the start cycle.
  - `clr_done_o` pulses in cycle S+65; IDLE resumes at S+65.
- Reset values with `rst_n`=0, asserted asynchronously:
  - State IDLE, pointer=write, counter=0.
  - `ram_cen_o`=1, `ram_wen_o`=1, `ram_adr_o`=0, `ram_wr_dat_o`=0.
  - All acks, `rd_val_o`, `clr_busy_o` and `clr_done_o` = 0.
- Reset mid-clear aborts the sequence; the RAM contents are then undefined.

## Configuration
- `DB_CBF_CLR_EN` defined: the CLEAR state, counter and clear ports are functional.
- `DB_CBF_CLR_EN` undefined:
  - Single-state arbiter only.
  - `clr_start_i` is ignored.
  - `clr_busy_o` and `clr_done_o` are tied to 0.

## Structure
- `CBF_ADR_W`, `CBF_DAT_W` and `CBF_CLR_VAL` defaults go in `enc_defines.v`, alongside the other deblocking constants.
- Sub-module `db_cbf_rr_arb`: 2-way round-robin arbiter with a write-priority override input (same-address case). It returns the grants and updates its pointer.

## Test plan
- Single write `adr`=5, `dat`=16'hA5A5, then read `adr`=5 → `wr_ack_o` at T; `rd_val_o` at T+2 with `rd_dat_o`=16'hA5A5.
- Both requests held, `wr_adr`=3 and `rd_adr`=7, for 4 cycles → grants alternate W,R,W,R; each ack is a single pulse.
- Simultaneous write 16'h1234 and read, both to `adr`=9 → write in T, read in T+1; `rd_dat_o`=16'h1234 at T+2.
- Fill all 64 addresses with 16'hFFFF, pulse `clr_start_i`:
  - `clr_busy_o` high for 64 cycles, then `clr_done_o` pulses.
  - All 64 reads return 16'h0000.
  - Requests raised during clear are acked only after `clr_done_o`.
- Assert `rst_n`=0 at clear cycle 20 → all outputs go to reset values asynchronously; after release, a `clr_start_i` pulse completes in 65 cycles.
- Build without `DB_CBF_CLR_EN`, pulse `clr_start_i` → `clr_busy_o`/`clr_done_o` stay 0 and reads/writes are served unchanged.

Source files
------------

// File: rtl/db_cbf_ram_ctrl_pkg.sv
// Shared constants and types for the deblocking CBF RAM access controller
// (default geometry of db_cbf_ram_sp_64x16 and the FSM state encoding).
package db_cbf_ram_ctrl_pkg;

  localparam int unsigned             CBF_ADR_W   = 6;
  localparam int unsigned             CBF_DAT_W   = 16;
  localparam logic [CBF_DAT_W-1:0]    CBF_CLR_VAL = 16'h0000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } cbf_state_e;

endpackage

// File: rtl/db_cbf_ram_ctrl_if.sv
// Requester-side bundle of the CBF RAM controller: write port, read port and
// read return path. slave = controller side, master = producer/filter side.
interface db_cbf_ram_ctrl_if
  import db_cbf_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADR_W = CBF_ADR_W,
  parameter int unsigned DAT_W = CBF_DAT_W
);

  logic             wr_req_i;
  logic [ADR_W-1:0] wr_adr_i;
  logic [DAT_W-1:0] wr_dat_i;
  logic             wr_ack_o;
  logic             rd_req_i;
  logic [ADR_W-1:0] rd_adr_i;
  logic             rd_ack_o;
  logic             rd_val_o;
  logic [DAT_W-1:0] rd_dat_o;

  modport slave (
    input  wr_req_i, wr_adr_i, wr_dat_i, rd_req_i, rd_adr_i,
    output wr_ack_o, rd_ack_o, rd_val_o, rd_dat_o
  );

  modport master (
    output wr_req_i, wr_adr_i, wr_dat_i, rd_req_i, rd_adr_i,
    input  wr_ack_o, rd_ack_o, rd_val_o, rd_dat_o
  );

endinterface

// File: rtl/db_cbf_rr_arb.sv
// Two-way round-robin arbiter for the CBF RAM port; wr_prio_i forces the write
// grant on contention without moving the pointer.
module db_cbf_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic wr_req_i,
  input  logic rd_req_i,
  input  logic wr_prio_i,
  output logic wr_gnt_c,
  output logic rd_gnt_c
);

  logic ptr_q, ptr_d;  // 0: write favoured on the next contended cycle

  always_comb begin
    wr_gnt_c = 1'b0;
    rd_gnt_c = 1'b0;
    ptr_d    = ptr_q;
    if (en_i) begin
      if (wr_req_i && rd_req_i) begin
        if (wr_prio_i) begin
          wr_gnt_c = 1'b1;
        end else begin
          wr_gnt_c = !ptr_q;
          rd_gnt_c = ptr_q;
          ptr_d    = !ptr_q;
        end
      end else begin
        wr_gnt_c = wr_req_i;
        rd_gnt_c = rd_req_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/db_cbf_ram_ctrl.sv
// Single-port access controller for the 64x16 deblocking CBF RAM: write/read
// arbitration plus a whole-RAM clear sequence enabled by DB_CBF_CLR_EN.
module db_cbf_ram_ctrl
  import db_cbf_ram_ctrl_pkg::*;
#(
  parameter int unsigned      ADR_W   = CBF_ADR_W,
  parameter int unsigned      DAT_W   = CBF_DAT_W,
  parameter logic [DAT_W-1:0] CLR_VAL = DAT_W'(CBF_CLR_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  db_cbf_ram_ctrl_if.slave req_if,
  input  logic             clr_start_i,
  output logic             clr_busy_o,
  output logic             clr_done_o,
  output logic             ram_cen_o,
  output logic             ram_wen_o,
  output logic [ADR_W-1:0] ram_adr_o,
  output logic [DAT_W-1:0] ram_wr_dat_o,
  input  logic [DAT_W-1:0] ram_rd_dat_i
);

  cbf_state_e       state_q, state_d;
  logic [ADR_W-1:0] cnt_q;
  logic [ADR_W-1:0] adr_hold_q, adr_hold_d;
  logic [DAT_W-1:0] dat_hold_q, dat_hold_d;
  logic             rd_val_q, rd_val_d;
  logic             arb_en_c, same_adr_c, wr_gnt_c, rd_gnt_c;

  // No access is issued while reset is held, even with requests pending
  assign arb_en_c   = rst_n && (state_q == ST_IDLE);
  assign same_adr_c = (req_if.wr_adr_i == req_if.rd_adr_i);

  db_cbf_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (arb_en_c),
    .wr_req_i  (req_if.wr_req_i),
    .rd_req_i  (req_if.rd_req_i),
    .wr_prio_i (same_adr_c),
    .wr_gnt_c  (wr_gnt_c),
    .rd_gnt_c  (rd_gnt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Clear runs from the cycle after the start pulse through the last-address write
  always_comb begin
    state_d = state_q;
`ifdef DB_CBF_CLR_EN
    case (state_q)
      ST_IDLE:  if (clr_start_i) state_d = ST_CLEAR;
      ST_CLEAR: if (cnt_q == '1) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
`endif
  end

  always_comb begin
    ram_cen_o       = 1'b1;
    ram_wen_o       = 1'b1;
    ram_adr_o       = adr_hold_q;
    ram_wr_dat_o    = dat_hold_q;
    req_if.wr_ack_o = 1'b0;
    req_if.rd_ack_o = 1'b0;
    if (state_q == ST_CLEAR) begin
      ram_cen_o    = 1'b0;
      ram_wen_o    = 1'b0;
      ram_adr_o    = cnt_q;
      ram_wr_dat_o = CLR_VAL;
    end else if (wr_gnt_c) begin
      ram_cen_o       = 1'b0;
      ram_wen_o       = 1'b0;
      ram_adr_o       = req_if.wr_adr_i;
      ram_wr_dat_o    = req_if.wr_dat_i;
      req_if.wr_ack_o = 1'b1;
    end else if (rd_gnt_c) begin
      ram_cen_o       = 1'b0;
      ram_adr_o       = req_if.rd_adr_i;
      req_if.rd_ack_o = 1'b1;
    end
  end

  // Idle cycles keep the RAM address/data buses at their last driven value
  assign adr_hold_d = ram_adr_o;
  assign dat_hold_d = ram_wr_dat_o;
  assign rd_val_d   = rd_gnt_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_hold_q <= '0;
      dat_hold_q <= '0;
      rd_val_q   <= 1'b0;
    end else begin
      adr_hold_q <= adr_hold_d;
      dat_hold_q <= dat_hold_d;
      rd_val_q   <= rd_val_d;
    end
  end

  assign req_if.rd_val_o = rd_val_q;
  assign req_if.rd_dat_o = ram_rd_dat_i;

`ifdef DB_CBF_CLR_EN
  logic [ADR_W-1:0] cnt_d;
  logic             done_q, done_d;

  // Clear address restarts on the start pulse and advances one word per cycle
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && clr_start_i) cnt_d = '0;
    else if (state_q == ST_CLEAR)          cnt_d = cnt_q + ADR_W'(1);
  end

  assign done_d = (state_q == ST_CLEAR) && (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign clr_busy_o = (state_q == ST_CLEAR);
  assign clr_done_o = done_q;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start_i;
  assign cnt_q            = '0;
  assign clr_busy_o       = 1'b0;
  assign clr_done_o       = 1'b0;
`endif

endmodule

// File: tb/tb_db_cbf_ram_ctrl.sv
// Scoreboard bench for db_cbf_ram_ctrl with a behavioural 64x16 single-port RAM;
// clear scenarios run when DB_CBF_CLR_EN is defined, else clear must be inert.
module tb_db_cbf_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        ram_cen;
  logic        ram_wen;
  logic [5:0]  ram_adr;
  logic [15:0] ram_wr_dat;
  logic [15:0] ram_rd_q = 16'h0;
  logic [15:0] mem    [64] = '{default: 16'h0};
  logic [15:0] shadow [64] = '{default: 16'h0};
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  db_cbf_ram_ctrl_if ifc ();

  db_cbf_ram_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (ifc.slave),
    .clr_start_i  (clr_start),
    .clr_busy_o   (clr_busy),
    .clr_done_o   (clr_done),
    .ram_cen_o    (ram_cen),
    .ram_wen_o    (ram_wen),
    .ram_adr_o    (ram_adr),
    .ram_wr_dat_o (ram_wr_dat),
    .ram_rd_dat_i (ram_rd_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen) mem[ram_adr] <= ram_wr_dat;
      else          ram_rd_q     <= mem[ram_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Read-return scoreboard
  always @(negedge clk) begin
    if (rst_n && ifc.rd_val_o) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("rd_dat", 32'(ifc.rd_dat_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic do_write(input logic [5:0] a, input logic [15:0] d, output int lat);
    lat = 0;
    ifc.wr_req_i = 1'b1; ifc.wr_adr_i = a; ifc.wr_dat_i = d;
    @(negedge clk);
    while (!ifc.wr_ack_o && lat < 200) begin lat++; @(negedge clk); end
    chk("wr_ack", 32'(ifc.wr_ack_o), 32'd1);
    chk("wr_ram", {ram_cen, ram_wen, ram_adr, ram_wr_dat}, {2'b00, a, d});
    if (ifc.wr_ack_o) shadow[a] = d;
    @(posedge clk); #1;
    ifc.wr_req_i = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output int lat);
    lat = 0;
    exp_q.push_back(shadow[a]);
    ifc.rd_req_i = 1'b1; ifc.rd_adr_i = a;
    @(negedge clk);
    while (!ifc.rd_ack_o && lat < 200) begin lat++; @(negedge clk); end
    chk("rd_ack", 32'(ifc.rd_ack_o), 32'd1);
    chk("rd_ram", {ram_cen, ram_wen, ram_adr}, {2'b01, a});
    @(posedge clk); #1;
    ifc.rd_req_i = 1'b0;
    @(negedge clk);
    chk("rd_val_lat", 32'(ifc.rd_val_o), 32'd1);
    @(posedge clk); #1;
  endtask

  // Raise write and read together; wfirst says which side the arbiter must pick first
  task automatic arb_pair(input string tag, input logic [5:0] wa, input logic [15:0] wd,
                          input logic [5:0] ra, input bit wfirst);
    exp_q.push_back((wfirst && wa == ra) ? wd : shadow[ra]);
    ifc.wr_req_i = 1'b1; ifc.wr_adr_i = wa; ifc.wr_dat_i = wd;
    ifc.rd_req_i = 1'b1; ifc.rd_adr_i = ra;
    @(negedge clk);
    chk({tag, "_1st"}, {ifc.wr_ack_o, ifc.rd_ack_o}, wfirst ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    if (wfirst) ifc.wr_req_i = 1'b0; else ifc.rd_req_i = 1'b0;
    @(negedge clk);
    chk({tag, "_2nd"}, {ifc.wr_ack_o, ifc.rd_ack_o}, wfirst ? 32'd1 : 32'd2);
    @(posedge clk); #1;
    ifc.wr_req_i = 1'b0; ifc.rd_req_i = 1'b0;
    shadow[wa] = wd;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [5:0] b2b_adr [4];
    rst_n = 1'b1; clr_start = 1'b0;
    ifc.wr_req_i = 1'b0; ifc.wr_adr_i = '0; ifc.wr_dat_i = '0;
    ifc.rd_req_i = 1'b0; ifc.rd_adr_i = '0;

    // Reset with both requests pending: nothing may reach the RAM
    #1 rst_n = 1'b0;
    ifc.wr_req_i = 1'b1; ifc.wr_adr_i = 6'd1; ifc.wr_dat_i = 16'h1111;
    ifc.rd_req_i = 1'b1; ifc.rd_adr_i = 6'd2;
    #2;
    chk("rst_ram", {ram_cen, ram_wen, ram_adr, ram_wr_dat}, {2'b11, 6'd0, 16'h0});
    chk("rst_ctl", {ifc.wr_ack_o, ifc.rd_ack_o, ifc.rd_val_o, clr_busy, clr_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold", {ram_cen, ifc.wr_ack_o, ifc.rd_ack_o, ifc.rd_val_o}, 32'b1000);
    ifc.wr_req_i = 1'b0; ifc.rd_req_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read the same word on consecutive cycles
    do_write(6'd5, 16'hA5A5, lat);
    chk("wr_lat", 32'(lat), 32'd0);
    do_read(6'd5, lat);
    chk("rd_lat", 32'(lat), 32'd0);

    // Held contention on different addresses alternates W,R,W,R
    exp_q.push_back(shadow[7]); exp_q.push_back(shadow[7]);
    ifc.wr_req_i = 1'b1; ifc.wr_adr_i = 6'd3; ifc.wr_dat_i = 16'h0303;
    ifc.rd_req_i = 1'b1; ifc.rd_adr_i = 6'd7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rr_alt", {ifc.wr_ack_o, ifc.rd_ack_o}, (c % 2 == 0) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
    end
    ifc.wr_req_i = 1'b0; ifc.rd_req_i = 1'b0;
    shadow[3] = 16'h0303;
    @(negedge clk);
    chk("rr_idle_cen", 32'(ram_cen), 32'd1);
    chk("rr_idle_hold", {ram_adr, ram_wr_dat}, {6'd7, 16'h0303});
    @(posedge clk); #1;

    arb_pair("rr_w_first", 6'd10, 16'hBEEF, 6'd11, 1'b1);
    arb_pair("same_adr",   6'd9,  16'h1234, 6'd9,  1'b1);
    arb_pair("ptr_kept",   6'd12, 16'h5555, 6'd10, 1'b0);

    // Back-to-back reads: one ack and one result per cycle
    b2b_adr[0] = 6'd3; b2b_adr[1] = 6'd5; b2b_adr[2] = 6'd9; b2b_adr[3] = 6'd10;
    for (int i = 0; i < 4; i++) exp_q.push_back(shadow[b2b_adr[i]]);
    ifc.rd_req_i = 1'b1; ifc.rd_adr_i = b2b_adr[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_ack", 32'(ifc.rd_ack_o), 32'd1);
      if (i > 0) chk("b2b_val", 32'(ifc.rd_val_o), 32'd1);
      @(posedge clk); #1;
      if (i < 3) ifc.rd_adr_i = b2b_adr[i+1];
    end
    ifc.rd_req_i = 1'b0;
    @(negedge clk);
    chk("b2b_val_last", 32'(ifc.rd_val_o), 32'd1);
    @(posedge clk); #1;

`ifdef DB_CBF_CLR_EN
    begin
      int busy_cnt = 0, done_cnt = 0, done_cyc = -1, early = 0;
      int wr_cyc = -1, rd_cyc = -1;
      for (int i = 0; i < 64; i++) do_write(6'(i), 16'hFFFF, lat);
      clr_start = 1'b1;
      @(negedge clk);
      chk("clr_busy_s", 32'(clr_busy), 32'd0);
      @(posedge clk); #1;
      clr_start = 1'b0;
      for (int c = 1; c <= 70; c++) begin
        if (c == 10) begin ifc.rd_req_i = 1'b1; ifc.rd_adr_i = 6'd20; exp_q.push_back(16'h0); end
        if (c == 12) begin ifc.wr_req_i = 1'b1; ifc.wr_adr_i = 6'd21; ifc.wr_dat_i = 16'h7777; end
        clr_start = (c == 30);
        @(negedge clk);
        if (clr_busy) busy_cnt++;
        if (clr_done) begin done_cnt++; done_cyc = c; end
        if (clr_busy && (ifc.wr_ack_o || ifc.rd_ack_o)) early++;
        if (ifc.wr_ack_o) wr_cyc = c;
        if (ifc.rd_ack_o) rd_cyc = c;
        if (c == 1)  chk("clr_first", {ram_cen, ram_wen, ram_adr, ram_wr_dat}, {2'b00, 6'd0, 16'h0});
        if (c == 64) chk("clr_last", {ram_cen, ram_wen, ram_adr}, {2'b00, 6'd63});
        @(posedge clk); #1;
        if (wr_cyc == c) ifc.wr_req_i = 1'b0;
        if (rd_cyc == c) ifc.rd_req_i = 1'b0;
      end
      clr_start = 1'b0;
      chk("clr_busy_cnt", 32'(busy_cnt), 32'd64);
      chk("clr_done_cnt", 32'(done_cnt), 32'd1);
      chk("clr_done_cyc", 32'(done_cyc), 32'd65);
      chk("clr_no_early_ack", 32'(early), 32'd0);
      chk("clr_wr_after", 32'(wr_cyc), 32'd65);
      chk("clr_rd_after", 32'(rd_cyc), 32'd66);
      for (int i = 0; i < 64; i++) shadow[i] = 16'h0;
      shadow[21] = 16'h7777;
      for (int i = 0; i < 64; i++) do_read(6'(i), lat);

      // Reset in clear cycle 20, then a full clear must still take 65 cycles
      clr_start = 1'b1;
      @(posedge clk); #1;
      clr_start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      chk("clr_busy_mid", 32'(clr_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("clr_rst_ram", {ram_cen, ram_wen, ram_adr, ram_wr_dat}, {2'b11, 6'd0, 16'h0});
      chk("clr_rst_ctl", {ifc.wr_ack_o, ifc.rd_ack_o, ifc.rd_val_o, clr_busy, clr_done}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clr_start = 1'b1;
      @(posedge clk); #1;
      clr_start = 1'b0;
      done_cyc = -1; busy_cnt = 0;
      for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
        @(negedge clk);
        if (clr_busy) busy_cnt++;
        if (clr_done) done_cyc = c;
        @(posedge clk); #1;
      end
      chk("clr2_done_cyc", 32'(done_cyc), 32'd65);
      chk("clr2_busy_cnt", 32'(busy_cnt), 32'd64);
      for (int i = 0; i < 64; i++) shadow[i] = 16'h0;
    end
`else
    begin
      int bad = 0;
      clr_start = 1'b1;
      @(posedge clk); #1;
      clr_start = 1'b0;
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        if (clr_busy || clr_done || !ram_cen) bad++;
      end
      chk("clr_ignored", 32'(bad), 32'd0);
      @(posedge clk); #1;
    end
`endif

    do_write(6'd33, 16'hC0DE, lat);
    do_read(6'd33, lat);
    do_write(6'd40, 16'h4242, lat);
    do_read(6'd40, lat);
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
